// File: rtl/hpdmc_wrdata.sv
// hpdmc_wrdata: DDR write-data sequencer (latency wait, preamble, beats, postamble).
// Optional HPDMC_WRDATA_UNDERRUN_CHECK_EN masks and flags FIFO-starved beats.
module hpdmc_wrdata #(
  parameter int WL    = 2,
  parameter int BURST = 4
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        wr_start_i,
  output logic        busy_o,
  input  logic [63:0] wdat_i,
  input  logic [7:0]  wmask_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [31:0] d0_o,
  output logic [31:0] d1_o,
  output logic [3:0]  dm0_o,
  output logic [3:0]  dm1_o,
  output logic        dq_oe_o,
  output logic        dqs_oe_o,
  output logic        dqs_en_o,
  input  logic        err_clr_i,
  output logic        underrun_o,
  output logic        proto_err_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_PRE  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_POST = 3'd4;

  localparam logic [3:0] LAT_LD  = 4'(WL - 1);
  localparam logic [4:0] BEAT_LD = 5'(BURST);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] lat;
  logic [3:0] lat_nxt;
  logic [4:0] beat;
  logic [4:0] beat_nxt;
  logic       starve;

`ifdef HPDMC_WRDATA_UNDERRUN_CHECK_EN
  assign starve = wready_o & ~wvalid_i;
`else
  logic unused_wvalid;
  assign unused_wvalid = wvalid_i;
  assign starve = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat;
    beat_nxt  = beat;
    unique case (state)
      S_IDLE: begin
        if (wr_start_i) begin
          lat_nxt   = LAT_LD;
          state_nxt = (WL == 1) ? S_PRE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat <= 4'd1) state_nxt = S_PRE;
        else lat_nxt = lat - 4'd1;
      end
      S_PRE: begin
        state_nxt = S_DATA;
        beat_nxt  = BEAT_LD;
      end
      S_DATA: begin
        beat_nxt = beat - 5'd1;
        if (beat <= 5'd1) state_nxt = S_POST;
      end
      S_POST: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE;
      lat   <= '0;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      lat   <= lat_nxt;
      beat  <= beat_nxt;
    end
  end

  // Controls are decoded from next state so every output leaves a flop.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_o   <= 1'b0;
      wready_o <= 1'b0;
      dqs_oe_o <= 1'b0;
      dqs_en_o <= 1'b0;
      dq_oe_o  <= 1'b0;
    end else begin
      busy_o   <= (state_nxt != S_IDLE);
      wready_o <= (state_nxt == S_PRE) |
                  ((state_nxt == S_DATA) & (beat_nxt > 5'd1));
      dqs_oe_o <= (state_nxt == S_PRE) |
                  (state_nxt == S_DATA) |
                  (state_nxt == S_POST);
      dqs_en_o <= (state_nxt == S_DATA);
      dq_oe_o  <= (state_nxt == S_DATA);
    end
  end

  // A fetch cycle is always followed by a DATA cycle.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      d0_o  <= '0;
      d1_o  <= '0;
      dm0_o <= 4'hF;
      dm1_o <= 4'hF;
    end else if (wready_o & ~starve) begin
      d0_o  <= wdat_i[63:32];
      d1_o  <= wdat_i[31:0];
      dm0_o <= ~wmask_i[7:4];
      dm1_o <= ~wmask_i[3:0];
    end else begin
      d0_o  <= '0;
      d1_o  <= '0;
      dm0_o <= 4'hF;
      dm1_o <= 4'hF;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      underrun_o  <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      underrun_o  <= starve | (underrun_o & ~err_clr_i);
      proto_err_o <= (wr_start_i & busy_o) |
                     (proto_err_o & ~err_clr_i);
    end
  end

endmodule

// File: tb/tb_hpdmc_wrdata.sv
// tb_hpdmc_wrdata: directed tables, corner sequences and a timing-rule model.
// Expectations follow HPDMC_WRDATA_UNDERRUN_CHECK_EN when it is defined.
module tb_hpdmc_wrdata;

  localparam int LWL = 2;
  localparam int LB  = 4;
`ifdef HPDMC_WRDATA_UNDERRUN_CHECK_EN
  localparam bit UEN = 1'b1;
`else
  localparam bit UEN = 1'b0;
`endif

  localparam logic [63:0] W1 = 64'h11111111_22222222;
  localparam logic [63:0] W2 = 64'h33333333_44444444;
  localparam logic [63:0] W3 = 64'h55555555_66666666;
  localparam logic [63:0] W4 = 64'h77777777_88888888;
  localparam logic [63:0] WX = 64'hDEADBEEF_CAFEF00D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st, wv, clr;
  logic [63:0] wd;
  logic [7:0]  wm;
  logic        busy, wr, dq, dqs, en, und, pe;
  logic [31:0] d0, d1;
  logic [3:0]  dm0, dm1;

  logic        b_st, b_wv, b_clr;
  logic [63:0] b_wd;
  logic [7:0]  b_wm;
  logic        b_busy, b_wr, b_dq, b_dqs, b_en, b_und, b_pe;
  logic [31:0] b_d0, b_d1;
  logic [3:0]  b_dm0, b_dm1;

  hpdmc_wrdata #(.WL(LWL), .BURST(LB)) dut (
    .clk_sys_i(clk), .rst_n_i(rst_n), .wr_start_i(st),
    .busy_o(busy), .wdat_i(wd), .wmask_i(wm), .wvalid_i(wv),
    .wready_o(wr), .d0_o(d0), .d1_o(d1), .dm0_o(dm0), .dm1_o(dm1),
    .dq_oe_o(dq), .dqs_oe_o(dqs), .dqs_en_o(en), .err_clr_i(clr),
    .underrun_o(und), .proto_err_o(pe)
  );

  hpdmc_wrdata #(.WL(1), .BURST(1)) dut_b (
    .clk_sys_i(clk), .rst_n_i(rst_n), .wr_start_i(b_st),
    .busy_o(b_busy), .wdat_i(b_wd), .wmask_i(b_wm), .wvalid_i(b_wv),
    .wready_o(b_wr), .d0_o(b_d0), .d1_o(b_d1), .dm0_o(b_dm0),
    .dm1_o(b_dm1), .dq_oe_o(b_dq), .dqs_oe_o(b_dqs), .dqs_en_o(b_en),
    .err_clr_i(b_clr), .underrun_o(b_und), .proto_err_o(b_pe)
  );

  typedef struct {
    logic        st;
    logic        wv;
    logic [63:0] wd;
    logic [7:0]  wm;
    logic        busy, wr, dq, dqs, en;
    logic [31:0] d0, d1;
    logic [3:0]  dm0, dm1;
  } vec_t;

  vec_t tbl[9];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit sel_b,
                         input logic e_busy, input logic e_wr,
                         input logic e_dq, input logic e_dqs,
                         input logic e_en, input logic [31:0] e_d0,
                         input logic [31:0] e_d1, input logic [3:0] e_dm0,
                         input logic [3:0] e_dm1, input logic e_und,
                         input logic e_pe);
    if (!sel_b) begin
      chk({tag, ".busy"}, {63'b0, busy}, {63'b0, e_busy});
      chk({tag, ".wready"}, {63'b0, wr}, {63'b0, e_wr});
      chk({tag, ".dq_oe"}, {63'b0, dq}, {63'b0, e_dq});
      chk({tag, ".dqs_oe"}, {63'b0, dqs}, {63'b0, e_dqs});
      chk({tag, ".dqs_en"}, {63'b0, en}, {63'b0, e_en});
      chk({tag, ".d0"}, {32'b0, d0}, {32'b0, e_d0});
      chk({tag, ".d1"}, {32'b0, d1}, {32'b0, e_d1});
      chk({tag, ".dm0"}, {60'b0, dm0}, {60'b0, e_dm0});
      chk({tag, ".dm1"}, {60'b0, dm1}, {60'b0, e_dm1});
      chk({tag, ".underrun"}, {63'b0, und}, {63'b0, e_und});
      chk({tag, ".proto_err"}, {63'b0, pe}, {63'b0, e_pe});
    end else begin
      chk({tag, ".busy"}, {63'b0, b_busy}, {63'b0, e_busy});
      chk({tag, ".wready"}, {63'b0, b_wr}, {63'b0, e_wr});
      chk({tag, ".dq_oe"}, {63'b0, b_dq}, {63'b0, e_dq});
      chk({tag, ".dqs_oe"}, {63'b0, b_dqs}, {63'b0, e_dqs});
      chk({tag, ".dqs_en"}, {63'b0, b_en}, {63'b0, e_en});
      chk({tag, ".d0"}, {32'b0, b_d0}, {32'b0, e_d0});
      chk({tag, ".d1"}, {32'b0, b_d1}, {32'b0, e_d1});
      chk({tag, ".dm0"}, {60'b0, b_dm0}, {60'b0, e_dm0});
      chk({tag, ".dm1"}, {60'b0, b_dm1}, {60'b0, e_dm1});
      chk({tag, ".underrun"}, {63'b0, b_und}, {63'b0, e_und});
      chk({tag, ".proto_err"}, {63'b0, b_pe}, {63'b0, e_pe});
    end
  endtask

  task automatic idle_inputs();
    st = 1'b0; wv = 1'b1; clr = 1'b0; wd = WX; wm = 8'hFF;
    b_st = 1'b0; b_wv = 1'b1; b_clr = 1'b0; b_wd = WX; b_wm = 8'hFF;
  endtask

  // Leaves the bench at the start of cycle 0, just after a clock edge.
  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tag);
    for (int c = 0; c < 9; c++) begin
      cyc = c;
      st = tbl[c].st; wv = tbl[c].wv; wd = tbl[c].wd; wm = tbl[c].wm;
      @(negedge clk);
      chk_all(tag, 1'b0, tbl[c].busy, tbl[c].wr, tbl[c].dq, tbl[c].dqs,
              tbl[c].en, tbl[c].d0, tbl[c].d1, tbl[c].dm0, tbl[c].dm1,
              1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  function automatic logic [63:0] wd_of(input int c);
    return {8'hA0, 24'(c), 8'hB0, 24'(c)};
  endfunction

  function automatic logic in_win(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  initial begin
    logic        e_busy, e_wr, e_dqs, e_dq, e_und, e_pe;
    logic        m_und, m_pe, m_busy;
    logic [31:0] e_d0, e_d1, bd0, bd1;
    logic [3:0]  e_dm0, e_dm1, bdm0, bdm1;
    int          t_start, rel;

    tbl[0] = '{1'b1, 1'b1, W1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               32'h0, 32'h0, 4'hF, 4'hF};
    tbl[1] = '{1'b0, 1'b1, W1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               32'h0, 32'h0, 4'hF, 4'hF};
    tbl[2] = '{1'b0, 1'b1, W1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
               32'h0, 32'h0, 4'hF, 4'hF};
    tbl[3] = '{1'b0, 1'b1, W2, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
               32'h11111111, 32'h22222222, 4'h0, 4'h0};
    tbl[4] = '{1'b0, 1'b1, W3, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
               32'h33333333, 32'h44444444, 4'h5, 4'hA};
    tbl[5] = '{1'b0, 1'b1, W4, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
               32'h55555555, 32'h66666666, 4'h0, 4'h0};
    tbl[6] = '{1'b0, 1'b1, WX, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
               32'h77777777, 32'h88888888, 4'h0, 4'h0};
    tbl[7] = '{1'b0, 1'b1, WX, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
               32'h0, 32'h0, 4'hF, 4'hF};
    tbl[8] = '{1'b0, 1'b1, WX, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               32'h0, 32'h0, 4'hF, 4'hF};

    // Basic burst with a masked second beat.
    reset_dut();
    run_table("basic");

    // Second start inside the burst is dropped; a start at cycle 8 runs.
    reset_dut();
    for (int c = 0; c < 17; c++) begin
      cyc = c;
      st = (c == 0) || (c == 4) || (c == 8);
      wd = W3;
      @(negedge clk);
      e_dq = in_win(c, 3, 6) | in_win(c, 11, 14);
      chk_all("proto", 1'b0,
              in_win(c, 1, 7) | in_win(c, 9, 15),
              in_win(c, 2, 5) | in_win(c, 10, 13),
              e_dq, in_win(c, 2, 7) | in_win(c, 10, 15), e_dq,
              e_dq ? 32'h55555555 : 32'h0, e_dq ? 32'h66666666 : 32'h0,
              e_dq ? 4'h0 : 4'hF, e_dq ? 4'h0 : 4'hF,
              1'b0, (c >= 5));
      @(posedge clk);
      #1;
    end
    idle_inputs();

    // FIFO empty on the third fetch, then the flag is cleared.
    reset_dut();
    for (int c = 0; c < 10; c++) begin
      cyc = c;
      st = (c == 0);
      wv = (c != 4);
      wd = wd_of(c);
      wm = 8'hFF;
      clr = (c == 8);
      @(negedge clk);
      e_dq = in_win(c, 3, 6);
      e_d0 = 32'h0; e_d1 = 32'h0; e_dm0 = 4'hF; e_dm1 = 4'hF;
      if (e_dq && !(UEN && c == 5)) begin
        e_d0 = wd_of(c - 1)[63:32];
        e_d1 = wd_of(c - 1)[31:0];
        e_dm0 = 4'h0; e_dm1 = 4'h0;
      end
      chk_all("underrun", 1'b0, in_win(c, 1, 7), in_win(c, 2, 5), e_dq,
              in_win(c, 2, 7), e_dq, e_d0, e_d1, e_dm0, e_dm1,
              UEN & in_win(c, 5, 8), 1'b0);
      @(posedge clk);
      #1;
    end
    idle_inputs();

    // Asynchronous reset mid-burst, then a clean burst.
    reset_dut();
    for (int c = 0; c < 4; c++) begin
      cyc = c;
      st = (c == 0);
      wd = W2;
      @(posedge clk);
      #1;
    end
    cyc = 4;
    chk("midrst.busy_before", {63'b0, busy}, 64'd1);
    chk("midrst.dq_before", {63'b0, dq}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            32'h0, 32'h0, 4'hF, 4'hF, 1'b0, 1'b0);
    reset_dut();
    run_table("after_rst");

    // WL=1, BURST=1 instance.
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      cyc = c;
      b_st = (c == 0);
      b_wd = W4;
      b_wm = 8'h3C;
      @(negedge clk);
      chk_all("wl1b1", 1'b1, in_win(c, 1, 3), (c == 1), (c == 2),
              in_win(c, 1, 3), (c == 2),
              (c == 2) ? 32'h77777777 : 32'h0,
              (c == 2) ? 32'h88888888 : 32'h0,
              (c == 2) ? 4'hC : 4'hF, (c == 2) ? 4'h3 : 4'hF,
              1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    idle_inputs();

    // Random traffic against the timing-window model.
    reset_dut();
    t_start = -1000;
    m_und = 1'b0; m_pe = 1'b0;
    bd0 = 32'h0; bd1 = 32'h0; bdm0 = 4'hF; bdm1 = 4'hF;
    for (int c = 0; c < 2500; c++) begin
      cyc = c;
      st  = ($urandom_range(0, 5) == 0);
      wv  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 15) == 0);
      wd  = {$urandom, $urandom};
      wm  = 8'($urandom);
      @(negedge clk);
      rel = c - t_start;
      e_busy = (rel >= 1) && (rel <= LWL + LB + 1);
      e_wr   = (rel >= LWL) && (rel <= LWL + LB - 1);
      e_dqs  = (rel >= LWL) && (rel <= LWL + LB + 1);
      e_dq   = (rel >= LWL + 1) && (rel <= LWL + LB);
      e_und  = m_und;
      e_pe   = m_pe;
      chk_all("rand", 1'b0, e_busy, e_wr, e_dq, e_dqs, e_dq,
              e_dq ? bd0 : 32'h0, e_dq ? bd1 : 32'h0,
              e_dq ? bdm0 : 4'hF, e_dq ? bdm1 : 4'hF, e_und, e_pe);
      m_busy = e_busy;
      if (e_wr) begin
        if (UEN && !wv) begin
          bd0 = 32'h0; bd1 = 32'h0; bdm0 = 4'hF; bdm1 = 4'hF;
        end else begin
          bd0 = wd[63:32]; bd1 = wd[31:0];
          bdm0 = ~wm[7:4]; bdm1 = ~wm[3:0];
        end
      end
      m_und = (UEN && e_wr && !wv) || (m_und && !clr);
      m_pe  = (st && m_busy) || (m_pe && !clr);
      if (st && !m_busy) t_start = c;
      @(posedge clk);
      #1;
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
